// File: rtl/jts16_rowscr_pkg.sv
// Shared definitions for the System 16B row-scroll fetch scheduler:
// FSM state encoding, default row-table base addresses, row-index width
// and the table address helper.
package jts16_rowscr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ1   = 2'd1,
        ST_REQ2   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    localparam logic [10:0] RBASE1_DEF = 11'h7C0;
    localparam logic [10:0] RBASE2_DEF = 11'h7E0;
    localparam int          ROW_W      = 5;

    // Table entry address: base plus row, truncated to 11 bits.
    function automatic logic [10:0] row_addr(input logic [10:0] base,
                                             input logic [ROW_W-1:0] row);
        return base + {{(11-ROW_W){1'b0}}, row};
    endfunction

endpackage

// File: rtl/jts16_rowscr_fetch.sv
// Row-scroll fetch scheduler. At each h-blank start it reads the per-row
// h-scroll words of layers 1 and 2 from char RAM (req/ok handshake) and
// publishes both effective h-scroll values together in one COMMIT cycle.
module jts16_rowscr_fetch
    import jts16_rowscr_pkg::*;
#(
    parameter logic [10:0] RBASE1 = RBASE1_DEF,
    parameter logic [10:0] RBASE2 = RBASE2_DEF
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        hstart,
    input  logic [8:0]  vnext,
    input  logic        rowscr1_en,
    input  logic        rowscr2_en,
    input  logic [15:0] scr1_hpos,
    input  logic [15:0] scr2_hpos,
    output logic [10:0] ram_addr,
    output logic        ram_req,
    input  logic        ram_ok,
    input  logic [15:0] ram_dout,
    output logic [9:0]  scr1_heff,
    output logic [9:0]  scr2_heff,
    output logic        busy,
    output logic        late
);

    state_t             r_state,   w_state;
    logic [ROW_W-1:0]   r_row,     w_row;
    logic               r_en2,     w_en2;
    logic [9:0]         r_shadow1, w_shadow1;
    logic [9:0]         r_shadow2, w_shadow2;
    logic [9:0]         r_heff1,   w_heff1;
    logic [9:0]         r_heff2,   w_heff2;
    logic [10:0]        r_addr,    w_addr;
    logic               r_req,     w_req;
    logic               r_busy,    w_busy;
    logic               r_late,    w_late;

    logic               w_start;
    logic               w_abort;
    logic               w_grant;
    logic [ROW_W-1:0]   w_vrow;
    logic               w_unused;

    assign w_grant  = r_req & ram_ok;
    assign w_vrow   = vnext[7:3];
    assign w_unused = ^{vnext[8], vnext[2:0], scr1_hpos[15:10],
                        scr2_hpos[15:10], ram_dout[15:10]};

    // Next-state and next-register logic for the fetch sequence.
    always_comb begin
        w_state   = r_state;
        w_row     = r_row;
        w_en2     = r_en2;
        w_shadow1 = r_shadow1;
        w_shadow2 = r_shadow2;
        w_heff1   = r_heff1;
        w_heff2   = r_heff2;
        w_addr    = r_addr;
        w_req     = r_req;
        w_busy    = r_busy;
        w_late    = r_late;
        w_start   = 1'b0;
        w_abort   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (hstart) begin
                    w_start = 1'b1;
                end else begin
                    w_start = 1'b0;
                end
            end
            ST_REQ1: begin
                if (hstart) begin
                    w_start = 1'b1;
                    w_abort = 1'b1;
                end else if (w_grant) begin
                    w_shadow1 = ram_dout[9:0];
                    if (r_en2) begin
                        w_state = ST_REQ2;
                        w_addr  = row_addr(RBASE2, r_row);
                        w_req   = 1'b1;
                    end else begin
                        w_state = ST_COMMIT;
                        w_req   = 1'b0;
                    end
                end else begin
                    // Holds the request; also raises it on the first cycle after an abort.
                    w_addr = row_addr(RBASE1, r_row);
                    w_req  = 1'b1;
                end
            end
            ST_REQ2: begin
                if (hstart) begin
                    w_start = 1'b1;
                    w_abort = 1'b1;
                end else if (w_grant) begin
                    w_shadow2 = ram_dout[9:0];
                    w_state   = ST_COMMIT;
                    w_req     = 1'b0;
                end else begin
                    w_addr = row_addr(RBASE2, r_row);
                    w_req  = 1'b1;
                end
            end
            ST_COMMIT: begin
                if (hstart) begin
                    w_start = 1'b1;
                    w_abort = 1'b1;
                end else begin
                    w_heff1 = r_shadow1;
                    w_heff2 = r_shadow2;
                    w_busy  = 1'b0;
                    w_state = ST_IDLE;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_req   = 1'b0;
                w_busy  = 1'b0;
            end
        endcase

        // A new line starts here, whether from IDLE or by aborting a running one.
        if (w_start) begin
            w_row  = w_vrow;
            w_en2  = rowscr2_en;
            w_busy = 1'b1;
            if (w_abort) begin
                w_late = 1'b1;
            end else begin
                w_late = r_late;
            end
            if (rowscr1_en) begin
                w_shadow1 = r_shadow1;
            end else begin
                w_shadow1 = scr1_hpos[9:0];
            end
            if (rowscr2_en) begin
                w_shadow2 = r_shadow2;
            end else begin
                w_shadow2 = scr2_hpos[9:0];
            end
            // After an abort the request drops for one cycle before re-asserting.
            if (rowscr1_en) begin
                w_state = ST_REQ1;
                w_addr  = row_addr(RBASE1, w_vrow);
                w_req   = ~w_abort;
            end else if (rowscr2_en) begin
                w_state = ST_REQ2;
                w_addr  = row_addr(RBASE2, w_vrow);
                w_req   = ~w_abort;
            end else begin
                w_state = ST_COMMIT;
                w_req   = 1'b0;
            end
        end else begin
            w_row = w_row;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_row     <= {ROW_W{1'b0}};
            r_en2     <= 1'b0;
            r_shadow1 <= 10'd0;
            r_shadow2 <= 10'd0;
            r_heff1   <= 10'd0;
            r_heff2   <= 10'd0;
            r_addr    <= 11'd0;
            r_req     <= 1'b0;
            r_busy    <= 1'b0;
            r_late    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_row     <= w_row;
            r_en2     <= w_en2;
            r_shadow1 <= w_shadow1;
            r_shadow2 <= w_shadow2;
            r_heff1   <= w_heff1;
            r_heff2   <= w_heff2;
            r_addr    <= w_addr;
            r_req     <= w_req;
            r_busy    <= w_busy;
            r_late    <= w_late;
        end
    end

    assign ram_addr  = r_addr;
    assign ram_req   = r_req;
    assign scr1_heff = r_heff1;
    assign scr2_heff = r_heff2;
    assign busy      = r_busy;
    assign late      = r_late;

endmodule
